// File: rtl/tron_pkg.sv
// Shared types for the tron game: game-state codes, score width and the
// score_keeper round FSM encoding.
package tron_pkg;

    typedef enum logic [2:0] {
        GS_MENU         = 3'd0,
        GS_ROUND_PAUSED = 3'd1,
        GS_ROUND_START  = 3'd2,
        GS_BLUE_WINS    = 3'd3,
        GS_RED_WINS     = 3'd4
    } game_state_t;

    localparam int SCORE_W = 2;
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PLAY,
        S_HOLD,
        S_FIRE,
        S_WAIT
    } score_state_t;

    // Saturating point increment; a score never wraps past SCORE_MAX.
    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
        return (s == SCORE_MAX) ? s : s + 1'b1;
    endfunction

endpackage

// File: rtl/score_keeper_hold_timer.sv
// hold_timer: counts frame ticks while a post-crash hold is active and flags
// the tick that completes HOLD_FRAMES of them.
module hold_timer #(
    parameter int HOLD_FRAMES = 60
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_start,
    input  logic i_tick,
    output logic o_done
);
    localparam int CNT_W = $clog2(HOLD_FRAMES + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(HOLD_FRAMES - 1);

    logic [CNT_W-1:0] r_cnt;

    // Held at zero outside the hold, so a tick in the crash cycle is never counted.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_start) begin
            r_cnt <= '0;
        end else if (i_tick) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_done = i_tick && (r_cnt == LAST);

endmodule

// File: rtl/score_keeper.sv
// score_keeper: round/match referee awarding points on bike crashes and issuing
// round-reset or match-winner pulses. Define SCORE_KEEPER_HOLD_EN for a frame-timed hold.
import tron_pkg::*;

module score_keeper #(
    parameter int WIN_SCORE   = 3,
    parameter int HOLD_FRAMES = 60
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Reset_Game,
    input  logic [2:0] Game_State,
    input  logic       frame_tick,
    input  logic       Blue_Crash,
    input  logic       Red_Crash,
    output logic [1:0] Score_B,
    output logic [1:0] Score_R,
    output logic       Round_Over,
    output logic       Reset_Round,
    output logic       Blue_W,
    output logic       Red_W
);
    localparam logic [SCORE_W-1:0] WIN = SCORE_W'(WIN_SCORE);

    score_state_t       r_state;
    logic [SCORE_W-1:0] r_score_b;
    logic [SCORE_W-1:0] r_score_r;
    logic               r_round_over;
    logic               r_reset_round;
    logic               r_blue_w;
    logic               r_red_w;

    logic w_rst;
    logic w_started;
    logic w_hold_done;

    assign w_rst     = Reset | Reset_Game;
    assign w_started = (game_state_t'(Game_State) == GS_ROUND_START);

`ifdef SCORE_KEEPER_HOLD_EN
    hold_timer #(
        .HOLD_FRAMES(HOLD_FRAMES)
    ) u_hold_timer (
        .i_clk  (Clk),
        .i_rst  (w_rst),
        .i_start(r_state != S_HOLD),
        .i_tick (frame_tick),
        .o_done (w_hold_done)
    );
`else
    logic w_unused_tick;
    assign w_unused_tick = frame_tick & (HOLD_FRAMES > 0);
    assign w_hold_done   = 1'b1;
`endif

    always_ff @(posedge Clk) begin
        if (w_rst) begin
            r_state       <= S_IDLE;
            r_score_b     <= '0;
            r_score_r     <= '0;
            r_round_over  <= 1'b0;
            r_reset_round <= 1'b0;
            r_blue_w      <= 1'b0;
            r_red_w       <= 1'b0;
        end else begin
            r_reset_round <= 1'b0;
            r_blue_w      <= 1'b0;
            r_red_w       <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (game_state_t'(Game_State) == GS_MENU) begin
                        r_score_b <= '0;
                        r_score_r <= '0;
                    end
                    if (w_started) begin
                        r_state <= S_PLAY;
                    end
                end
                S_PLAY: begin
                    if (!w_started) begin
                        r_state <= S_IDLE;
                    end else if (Blue_Crash || Red_Crash) begin
                        // A simultaneous crash is a draw: enter the hold with no award.
                        if (Red_Crash && !Blue_Crash) begin
                            r_score_b <= sat_inc(r_score_b);
                        end
                        if (Blue_Crash && !Red_Crash) begin
                            r_score_r <= sat_inc(r_score_r);
                        end
                        r_round_over <= 1'b1;
                        r_state      <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (!w_started) begin
                        r_round_over <= 1'b0;
                        r_state      <= S_IDLE;
                    end else if (w_hold_done) begin
                        r_round_over <= 1'b0;
                        r_state      <= S_FIRE;
                        if (r_score_b == WIN) begin
                            r_blue_w <= 1'b1;
                        end else if (r_score_r == WIN) begin
                            r_red_w <= 1'b1;
                        end else begin
                            r_reset_round <= 1'b1;
                        end
                    end
                end
                S_FIRE: begin
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    // Stay parked until the round ends so held crash flags cannot score twice.
                    if (!w_started) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign Score_B     = r_score_b;
    assign Score_R     = r_score_r;
    assign Round_Over  = r_round_over;
    assign Reset_Round = r_reset_round;
    assign Blue_W      = r_blue_w;
    assign Red_W       = r_red_w;

endmodule

// File: tb/tb_score_keeper.sv
// Randomized round-level bench for score_keeper; expected scores and pulses come
// from a per-round model of the referee rules (follows SCORE_KEEPER_HOLD_EN).
module tb_score_keeper;

    localparam int WIN   = 3;
    localparam int HOLDF = 2;

    logic       Clk = 1'b0;
    logic       Reset, Reset_Game, frame_tick, Blue_Crash, Red_Crash;
    logic [2:0] Game_State;
    logic [1:0] Score_B, Score_R;
    logic       Round_Over, Reset_Round, Blue_W, Red_W;

    int n_vec = 0;
    int n_err = 0;
    int exp_b = 0;
    int exp_r = 0;

    score_keeper #(.WIN_SCORE(WIN), .HOLD_FRAMES(HOLDF)) dut (
        .Clk(Clk), .Reset(Reset), .Reset_Game(Reset_Game), .Game_State(Game_State),
        .frame_tick(frame_tick), .Blue_Crash(Blue_Crash), .Red_Crash(Red_Crash),
        .Score_B(Score_B), .Score_R(Score_R), .Round_Over(Round_Over),
        .Reset_Round(Reset_Round), .Blue_W(Blue_W), .Red_W(Red_W)
    );

    always #5 Clk = ~Clk;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_vec++;
        if (got !== expv) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, expv);
        end
    endtask

    task automatic check_all(input string tag, input bit ro, input bit rr, input bit bw, input bit rw);
        chk({tag, ".score_b"}, Score_B, exp_b);
        chk({tag, ".score_r"}, Score_R, exp_r);
        chk({tag, ".round_over"}, Round_Over, ro);
        chk({tag, ".reset_round"}, Reset_Round, rr);
        chk({tag, ".blue_w"}, Blue_W, bw);
        chk({tag, ".red_w"}, Red_W, rw);
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    function automatic int sat3(input int v);
        return (v > 3) ? 3 : v;
    endfunction

    // kind: 1 red crashes (blue scores), 2 blue crashes (red scores), 3 both (draw)
    // abort_at: -1 none, 0 leave during play, 1 leave during hold
    task automatic play_round(input int kind, input bit hold_crash, input int abort_at);
        int winner;
        int ticks;
        int guard;
        Game_State = 3'd2;
        step();
        check_all("start", 0, 0, 0, 0);
        repeat ($urandom_range(0, 3)) begin
            frame_tick = $urandom_range(0, 1);
            step();
            check_all("play", 0, 0, 0, 0);
        end
        frame_tick = 1'b0;
        if (abort_at == 0) begin
            Game_State = 3'd1;
            step();
            check_all("abort_play", 0, 0, 0, 0);
            return;
        end
        Red_Crash  = (kind == 1) || (kind == 3);
        Blue_Crash = (kind == 2) || (kind == 3);
        frame_tick = $urandom_range(0, 1);
        step();
        if (kind == 1) exp_b = sat3(exp_b + 1);
        if (kind == 2) exp_r = sat3(exp_r + 1);
        check_all("crash", 1, 0, 0, 0);
        if (!hold_crash) begin
            Red_Crash  = 1'b0;
            Blue_Crash = 1'b0;
        end
        frame_tick = 1'b0;
        winner = (exp_b == WIN) ? 1 : (exp_r == WIN) ? 2 : 0;
`ifdef SCORE_KEEPER_HOLD_EN
        ticks = 0;
        guard = 0;
        while (ticks < HOLDF) begin
            if (abort_at == 1 && guard == 1) begin
                Game_State = 3'd1;
                frame_tick = 1'b0;
                step();
                check_all("abort_hold", 0, 0, 0, 0);
                Red_Crash  = 1'b0;
                Blue_Crash = 1'b0;
                return;
            end
            frame_tick = (guard > 20) || ($urandom_range(0, 2) == 0);
            step();
            guard++;
            if (frame_tick) ticks++;
            if (ticks < HOLDF) check_all("hold", 1, 0, 0, 0);
        end
        frame_tick = 1'b0;
`else
        ticks = 0;
        guard = 0;
        if (abort_at == 1) begin
            Game_State = 3'd1;
            step();
            check_all("abort_hold", 0, 0, 0, 0);
            Red_Crash  = 1'b0;
            Blue_Crash = 1'b0;
            return;
        end
        frame_tick = $urandom_range(0, 1);
        step();
        frame_tick = 1'b0;
`endif
        check_all("fire", 0, winner == 0, winner == 1, winner == 2);
        repeat ($urandom_range(1, 3)) begin
            frame_tick = $urandom_range(0, 1);
            step();
            check_all("wait", 0, 0, 0, 0);
        end
        frame_tick = 1'b0;
        Red_Crash  = 1'b0;
        Blue_Crash = 1'b0;
        if (winner != 0) begin
            Game_State = (winner == 1) ? 3'd3 : 3'd4;
            step();
            check_all("post_win", 0, 0, 0, 0);
            step();
            check_all("win_hold", 0, 0, 0, 0);
            Game_State = 3'd0;
            step();
            exp_b = 0;
            exp_r = 0;
            check_all("menu_clear", 0, 0, 0, 0);
        end else begin
            Game_State = 3'd1;
            step();
            check_all("pause", 0, 0, 0, 0);
        end
    endtask

    initial begin
        Reset = 1'b1; Reset_Game = 1'b0; Game_State = 3'd0;
        frame_tick = 1'b0; Blue_Crash = 1'b0; Red_Crash = 1'b0;
        step();
        step();
        check_all("reset", 0, 0, 0, 0);
        Reset = 1'b0;
        step();
        check_all("after_reset", 0, 0, 0, 0);

        play_round(1, 1'b0, -1);
        play_round(3, 1'b0, -1);
        play_round(2, 1'b1, -1);

        // Reset_Game in the hold with scores 2/1
        play_round(1, 1'b0, -1);
        Game_State = 3'd2;
        step();
        Red_Crash = 1'b1;
        Blue_Crash = 1'b1;
        step();
        check_all("pre_reset_hold", 1, 0, 0, 0);
        chk("scores_2_1", {Score_B, Score_R}, 4'b1001);
        Red_Crash = 1'b0;
        Blue_Crash = 1'b0;
        Reset_Game = 1'b1;
        step();
        exp_b = 0;
        exp_r = 0;
        check_all("reset_hold", 0, 0, 0, 0);
        Reset_Game = 1'b0;
        step();
        check_all("reset_hold_next", 0, 0, 0, 0);
        Game_State = 3'd1;
        step();
        check_all("reset_hold_idle", 0, 0, 0, 0);

        // Red wins the match, then blue wins one (with held crash flags)
        repeat (3) play_round(2, 1'b0, -1);
        repeat (3) play_round(1, 1'b1, -1);
        play_round(1, 1'b0, 0);
        play_round(2, 1'b0, 1);

        for (int i = 0; i < 60; i++) begin
            int k;
            int a;
            k = $urandom_range(1, 3);
            a = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 1) : -1;
            play_round(k, $urandom_range(0, 1), a);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/score_keeper.md
# score_keeper

Round and match referee feeding the game state machine. It watches both bikes' crash flags while a round is running and awards points. After a post-crash hold it issues either a one-cycle round-reset request or a one-cycle match-winner pulse. It drives `Score_B`, `Score_R`, `Blue_W`, `Red_W` and `Reset_Round` into the game state machine, and consumes its `Game_State` output.

## Interface
- `WIN_SCORE`, default 3: points needed to win a match; legal range 1..3 because scores are 2-bit.
- `HOLD_FRAMES`, default 60: number of `frame_tick` pulses in the post-crash hold.
- `Clk` in 1: system clock. One clock domain only.
- `Reset` in 1: synchronous, active-high, global reset.
- `Reset_Game` in 1: synchronous, active-high match reset. Same effect as `Reset`.
- `Game_State` in 3: current game state code. Values 0 Menu, 1 Round_Paused, 2 Round_Started, 3 Blue_Wins, 4 Red_Wins.
- `frame_tick` in 1: one-cycle pulse per video frame.
- `Blue_Crash` in 1: level signal; blue bike has collided.
- `Red_Crash` in 1: level signal; red bike has collided.
- `Score_B` out 2: blue point count.
- `Score_R` out 2: red point count.
- `Round_Over` out 1: high from the crash through the end of the hold. Bike movement freezes on it.
- `Reset_Round` out 1: one-cycle pulse requesting a new round.
- `Blue_W` out 1: one-cycle pulse; blue has won the match.
- `Red_W` out 1: one-cycle pulse; red has won the match.

## Operation
- The FSM has five states: IDLE, PLAY, HOLD, FIRE, WAIT.
- IDLE:
  - Go to PLAY when `Game_State` == 2.
  - Clear both scores to 0 when `Game_State` == 0.
- PLAY: sample the crash flags every cycle, then go to HOLD.
  - `Red_Crash` alone: `Score_B` +1.
  - `Blue_Crash` alone: `Score_R` +1.
  - Both flags in the same cycle: draw. No points awarded.
- HOLD: count `frame_tick` pulses. When the count reaches `HOLD_FRAMES`, go to FIRE. Crash flags are ignored.
- FIRE lasts exactly one cycle and asserts exactly one output:
  - `Blue_W` if `Score_B` == `WIN_SCORE`;
  - otherwise `Red_W` if `Score_R` == `WIN_SCORE`;
  - otherwise `Reset_Round`.
  - Then go to WAIT.
- WAIT: go to IDLE when `Game_State` != 2. This prevents a second award in the same round.
- Scores saturate at 3. Scores are held through the Blue_Wins and Red_Wins states and are cleared only in Menu or on reset.
- If `Game_State` leaves 2 during PLAY or HOLD, go to IDLE. No pulse is issued and any score already awarded is kept.
- Both scores reaching `WIN_SCORE` at once is impossible, because a draw awards no points.
- Reset values: `Reset` or `Reset_Game` forces state IDLE, hold count 0, and both scores 0. Reset takes priority over every other event in the same cycle.
- Output reset values: every output is 0.

## Timing
- Crash sampled in PLAY at cycle N:
  - state is HOLD at N+1;
  - updated score is visible at N+1;
  - `Round_Over` is 1 from N+1.
- Hold count increments on `frame_tick` only. A tick arriving in the same cycle as the crash is not counted.
- FIRE starts the cycle after the `HOLD_FRAMES`-th tick.
- `Round_Over` falls in the FIRE cycle. The pulse output is high in that cycle only.
- The game state machine moves on the pulse one cycle later, and this block reaches IDLE one cycle after that.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- Macro: `SCORE_KEEPER_HOLD_EN`.
- Defined: HOLD waits `HOLD_FRAMES` frame ticks as described above.
- Undefined: HOLD lasts exactly one cycle and ignores `frame_tick`. The hold counter is not instantiated, so FIRE occurs at crash cycle N+2.

## Structure
- Package `tron_pkg` holds:
  - the 3-bit `game_state_t` enum, with values 0..4 as listed under Interface;
  - the score width constant, 2;
  - the `score_state_t` FSM enum.
- Sub-module `hold_timer` is a frame-tick counter with `start` and `done` signals, parameterised by `HOLD_FRAMES`. It is instantiated only when `SCORE_KEEPER_HOLD_EN` is defined.

## Test plan
- Red-crash round:
  - stimulus: `Game_State`=2, `HOLD_FRAMES`=2; pulse `Red_Crash`, then deliver 2 ticks;
  - required: `Score_B`=1 one cycle after the crash; `Reset_Round` high for one cycle after the 2nd tick; `Blue_W` and `Red_W` stay 0.
- Simultaneous crash:
  - stimulus: `Blue_Crash` and `Red_Crash` asserted in the same cycle;
  - required: both scores stay 0; `Reset_Round` pulses once.
- Match win:
  - stimulus: `Score_R`=2, `WIN_SCORE`=3; `Blue_Crash` asserted;
  - required: `Score_R`=3; `Red_W` pulses once; no `Reset_Round`.
- Crash held across states:
  - stimulus: `Blue_Crash` held high through HOLD, FIRE and WAIT;
  - required: exactly one point is awarded and exactly one pulse is issued.
- Reset mid-hold:
  - stimulus: `Reset_Game` asserted in HOLD with scores at 2/1;
  - required: scores 0/0, `Round_Over` 0 and no pulse on the next cycle.
- Clear on menu:
  - stimulus: `Game_State`=0 after a Blue_Wins match;
  - required: both scores become 0 one cycle later.
